// File: rtl/cr16_alu_defs.sv
// Shared definitions for the CR16 multi-cycle ALU: opcodes, FSM states, status bits.
package cr16_alu_defs;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDU  = 4'd1;
    localparam logic [3:0] OP_ADDC  = 4'd2;
    localparam logic [3:0] OP_ADDCU = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_CMP   = 4'd5;
    localparam logic [3:0] OP_SUBU  = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_NOT   = 4'd10;
    localparam logic [3:0] OP_LSH   = 4'd11;
    localparam logic [3:0] OP_RSH   = 4'd12;
    localparam logic [3:0] OP_ALSH  = 4'd13;
    localparam logic [3:0] OP_ARSH  = 4'd14;
    localparam logic [3:0] OP_MUL   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_e;

    // Bit positions inside the 5-bit status word {N, Z, F, L, C}
    localparam int STAT_N = 4;
    localparam int STAT_Z = 3;
    localparam int STAT_F = 2;
    localparam int STAT_L = 1;
    localparam int STAT_C = 0;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op >= OP_LSH) && (op <= OP_ARSH);
    endfunction

endpackage

// File: rtl/cr16_alu_iter.sv
// Iterative datapath: one-bit-per-cycle shifter and shift-add multiplier.
// The multiplier keeps the product in {hi_q, lo_q}; lo_q starts as the
// multiplier and doubles as the shift register for shift ops.
module cr16_alu_iter #(
    parameter int P_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       load,
    input  logic                       load_mul,
    input  logic                       load_left,
    input  logic                       load_arith,
    input  logic [$clog2(P_WIDTH):0]   load_cnt,
    input  logic [P_WIDTH-1:0]         a,
    input  logic [P_WIDTH-1:0]         b,
    input  logic                       step,
    input  logic                       is_mul,
    output logic                       last,
    output logic [P_WIDTH-1:0]         res,
    output logic                       hi_nz
);
    localparam int CW = $clog2(P_WIDTH) + 1;

    logic [P_WIDTH-1:0] a_q, hi_q, lo_q, hi_n, lo_n;
    logic [CW-1:0]      cnt_q;
    logic               left_q, arith_q;
    logic [P_WIDTH:0]   sum;

    // Next value of the datapath after one iteration
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        hi_n = hi_q;
        lo_n = lo_q;
        if (is_mul) begin
            hi_n = sum[P_WIDTH:1];
            lo_n = {sum[0], lo_q[P_WIDTH-1:1]};
        end else if (left_q) begin
            lo_n = {lo_q[P_WIDTH-2:0], 1'b0};
        end else begin
            lo_n = {arith_q & lo_q[P_WIDTH-1], lo_q[P_WIDTH-1:1]};
        end
    end

    assign last  = (cnt_q == CW'(1));
    assign res   = lo_n;
    assign hi_nz = |hi_n;

    // Operand load on accept, one iteration per enabled cycle afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (en) begin
            if (load) begin
                a_q     <= a;
                hi_q    <= '0;
                lo_q    <= load_mul ? b : a;
                cnt_q   <= load_cnt;
                left_q  <= load_left;
                arith_q <= load_arith;
            end else if (step) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/cr16_alu_mc.sv
// CR16 ALU: single-cycle arithmetic/logic plus iterative shifts and multiply.
module cr16_alu_mc
    import cr16_alu_defs::*;
#(
    parameter int P_WIDTH  = 16,
    parameter int P_MUL_EN = 1
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_ENABLE,
    input  logic               I_VALID,
    input  logic [3:0]         I_OPCODE,
    input  logic [P_WIDTH-1:0] I_A,
    input  logic [P_WIDTH-1:0] I_B,
    output logic               O_READY,
    output logic               O_VALID,
    output logic [P_WIDTH-1:0] O_C,
    output logic [4:0]         O_STATUS
);
    localparam int AW = $clog2(P_WIDTH) + 1;
    localparam int M  = P_WIDTH - 1;

    state_e             state_q, state_n;
    logic               accept, go_shift, go_mul, fin;
    logic [AW-1:0]      amt, s_amt;
    logic               iter_last, iter_hi_nz;
    logic [P_WIDTH-1:0] iter_res;
    logic [P_WIDTH:0]   sum, dif;
    logic               cin, add_ovf, sub_ovf, wr_c;
    logic [P_WIDTH-1:0] sc_res;
    logic [4:0]         sc_status, fin_status;

    // Shift amounts past the width saturate: everything is fill by then
    assign amt   = I_B[AW-1:0];
    assign s_amt = (amt > AW'(P_WIDTH)) ? AW'(P_WIDTH) : amt;

    // FSM state register; I_ENABLE low freezes it
    always_ff @(posedge I_CLK) begin
        if (I_RESET)       state_q <= ST_IDLE;
        else if (I_ENABLE) state_q <= state_n;
    end

    // Next state, handshake and iteration control
    always_comb begin
        state_n  = state_q;
        O_READY  = 1'b0;
        accept   = 1'b0;
        go_shift = 1'b0;
        go_mul   = 1'b0;
        fin      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                O_READY = I_ENABLE;
                accept  = I_ENABLE & I_VALID;
                if (accept && is_shift_op(I_OPCODE) && (s_amt != '0)) begin
                    go_shift = 1'b1;
                    state_n  = ST_SHIFT;
                end else if (accept && (I_OPCODE == OP_MUL) && (P_MUL_EN != 0)) begin
                    go_mul  = 1'b1;
                    state_n = ST_MUL;
                end
            end
            ST_SHIFT, ST_MUL: begin
                if (I_ENABLE && iter_last) begin
                    fin     = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    cr16_alu_iter #(.P_WIDTH(P_WIDTH)) u_iter (
        .clk        (I_CLK),
        .rst        (I_RESET),
        .en         (I_ENABLE),
        .load       (go_shift | go_mul),
        .load_mul   (go_mul),
        .load_left  ((I_OPCODE == OP_LSH) || (I_OPCODE == OP_ALSH)),
        .load_arith (I_OPCODE == OP_ARSH),
        .load_cnt   (go_mul ? AW'(P_WIDTH) : s_amt),
        .a          (I_A),
        .b          (I_B),
        .step       (state_q != ST_IDLE),
        .is_mul     (state_q == ST_MUL),
        .last       (iter_last),
        .res        (iter_res),
        .hi_nz      (iter_hi_nz)
    );

    // Single-cycle result and flags; CMP only updates flags
    always_comb begin
        cin       = ((I_OPCODE == OP_ADDC) || (I_OPCODE == OP_ADDCU)) ? O_STATUS[STAT_C] : 1'b0;
        sum       = {1'b0, I_A} + {1'b0, I_B} + (P_WIDTH+1)'(cin);
        dif       = {1'b0, I_A} - {1'b0, I_B};
        add_ovf   = (I_A[M] == I_B[M]) && (sum[M] != I_A[M]);
        sub_ovf   = (I_A[M] != I_B[M]) && (dif[M] != I_A[M]);
        sc_res    = '0;
        sc_status = '0;
        wr_c      = 1'b1;
        case (I_OPCODE)
            OP_ADD, OP_ADDC: begin
                sc_res            = sum[M:0];
                sc_status[STAT_N] = sum[M];
                sc_status[STAT_F] = add_ovf;
                sc_status[STAT_C] = sum[P_WIDTH];
            end
            OP_ADDU, OP_ADDCU: begin
                sc_res            = sum[M:0];
                sc_status[STAT_C] = sum[P_WIDTH];
            end
            OP_SUB, OP_CMP: begin
                sc_res            = dif[M:0];
                sc_status[STAT_N] = dif[M];
                sc_status[STAT_F] = sub_ovf;
                sc_status[STAT_L] = I_B < I_A;
                sc_status[STAT_C] = dif[P_WIDTH];
                wr_c              = (I_OPCODE != OP_CMP);
            end
            OP_SUBU: begin
                sc_res            = dif[M:0];
                sc_status[STAT_L] = I_B < I_A;
                sc_status[STAT_C] = dif[P_WIDTH];
            end
            OP_AND: sc_res = I_A & I_B;
            OP_OR:  sc_res = I_A | I_B;
            OP_XOR: sc_res = I_A ^ I_B;
            OP_NOT: sc_res = ~I_A;
            OP_LSH, OP_RSH, OP_ALSH, OP_ARSH: sc_res = I_A;
            OP_MUL: sc_res = '0;
            default: sc_res = '0;
        endcase
        if (I_OPCODE inside {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_RSH, OP_ALSH, OP_ARSH})
            sc_status[STAT_N] = sc_res[M];
        sc_status[STAT_Z] = (I_OPCODE == OP_CMP) ? (I_A == I_B) : (sc_res == '0);

        fin_status         = '0;
        fin_status[STAT_N] = (state_q == ST_SHIFT) & iter_res[M];
        fin_status[STAT_Z] = (iter_res == '0);
        fin_status[STAT_C] = (state_q == ST_MUL) & iter_hi_nz;
    end

    // Result/status registers and the one-cycle completion pulse
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            O_C      <= '0;
            O_STATUS <= '0;
            O_VALID  <= 1'b0;
        end else begin
            O_VALID <= 1'b0;
            if (fin) begin
                O_C      <= iter_res;
                O_STATUS <= fin_status;
                O_VALID  <= 1'b1;
            end else if (accept && !go_shift && !go_mul) begin
                if (wr_c) O_C <= sc_res;
                O_STATUS <= sc_status;
                O_VALID  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cr16_alu_mc.md
CR16_ALU_MC -- requirements
Module: cr16_alu_mc

Interface
REQ-001 Parameter P_WIDTH, default 16, datapath width; legal values 8, 16, 32.
REQ-002 Parameter P_MUL_EN, default 1; 1 = opcode 15 is an iterative multiply, 0 = opcode 15 returns 0.
REQ-003 I_CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 I_RESET  in  1  reset, synchronous, active-high.
REQ-005 I_ENABLE  in  1  global advance enable; low freezes all state.
REQ-006 I_VALID  in  1  operation offered this cycle.
REQ-007 I_OPCODE  in  4  operation select, per REQ-013.
REQ-008 I_A, I_B  in  P_WIDTH  operands; I_B low clog2(P_WIDTH)+1 bits give the shift amount.
REQ-009 O_READY  out  1  operation accepted when I_VALID and O_READY are both high.
REQ-010 O_VALID  out  1  one-cycle pulse: O_C and O_STATUS are updated this cycle.
REQ-011 O_C  out  P_WIDTH  result; held between pulses.
REQ-012 O_STATUS  out  5  flags {N[4], Z[3], F[2], L[1], C[0]}; held between pulses.

Function
REQ-013 Opcodes: 0 ADD, 1 ADDU, 2 ADDC, 3 ADDCU, 4 SUB, 5 CMP, 6 SUBU, 7 AND, 8 OR, 9 XOR, 10 NOT(A), 11 LSH, 12 RSH, 13 ALSH, 14 ARSH, 15 MUL.
REQ-014 Opcodes 0-10 are single-cycle: accept at edge k, O_VALID high in cycle k+1, O_READY stays high.
REQ-015 ADDC and ADDCU add the stored C flag as carry-in.
REQ-016 CMP updates flags as for SUB and leaves O_C unchanged.
REQ-017 Shifts take s = min(I_B amount, P_WIDTH) and move one bit per cycle.
REQ-018 Shift latency is 1+s cycles; s=0 gives latency 1.
REQ-019 Shift fill: LSH, ALSH, RSH fill with 0; ARSH fills with the sign bit; amounts >= P_WIDTH give all-fill.
REQ-020 MUL is a shift-add over P_WIDTH iterations, latency P_WIDTH+1; O_C is the low P_WIDTH bits of the unsigned product.
REQ-021 FSM states: IDLE, SHIFT, MUL.
REQ-022 Transitions: IDLE to SHIFT on an accepted shift with s>0; IDLE to MUL on an accepted MUL; SHIFT/MUL to IDLE on the final iteration, with O_VALID in the following cycle.
REQ-023 O_READY = I_ENABLE and state==IDLE; in SHIFT and MUL, I_VALID is ignored.
REQ-024 A new operation may be accepted in the same cycle O_VALID pulses.
REQ-025 Z = (O_C==0) for every op except CMP, where Z = (A==B).
REQ-026 N = result MSB for signed/logic/shift ops; N = 0 for ADDU, ADDCU, SUBU, MUL.
REQ-027 F = signed overflow for ADD, ADDC, SUB, CMP; F = 0 otherwise.
REQ-028 C = carry-out for add ops; C = borrow for SUB, SUBU, CMP; C = (product high half != 0) for MUL; C = 0 otherwise.
REQ-029 L = unsigned (I_B < I_A) for SUB, SUBU, CMP; L = 0 otherwise.
REQ-030 I_ENABLE low holds state, counters, O_C and O_STATUS, and suppresses O_VALID; operation resumes exactly when I_ENABLE returns high.

Reset
REQ-031 While I_RESET is high at an edge: state=IDLE, O_C=0, O_STATUS=0, O_VALID=0, stored C=0, iteration counter=0.
REQ-032 After that edge, O_READY follows REQ-023.
REQ-033 I_RESET takes priority over I_ENABLE and aborts any in-flight shift or MUL with no O_VALID.

Structure
REQ-034 Opcode constants, FSM state encodings and O_STATUS bit indices reside in shared header cr16_alu_defs, used by the RTL and the bench.
REQ-035 The iterative shift/multiply datapath (operand registers, counter, accumulator) is sub-module cr16_alu_iter; the single-cycle ops and flags stay in cr16_alu_mc.

Verification (P_WIDTH=16)
REQ-036 ADDU 0xFFFF+0x0001 -> O_C=0x0000, Z=1, C=1; then ADDCU 0x0000+0x0000 -> O_C=0x0001, C=0.
REQ-037 ADD 0x7FFF+0x0001 -> O_C=0x8000, F=1, N=1, Z=0; then CMP A=5 B=3 -> O_C still 0x8000, L=1, Z=0, C=0.
REQ-038 ARSH A=0x8000 B=3 -> O_READY low 3 cycles, a concurrent I_VALID is ignored, O_VALID 4 cycles after accept, O_C=0xF000, N=1; ARSH B=20 -> O_C=0xFFFF.
REQ-039 MUL 0x0100*0x0100 -> O_VALID 17 cycles after accept, O_C=0x0000, Z=1, C=1; MUL 0x0003*0x0005 -> O_C=0x000F, C=0.
REQ-040 I_RESET asserted at cycle 5 of a MUL -> next cycle O_READY=1, O_VALID=0, O_STATUS=0, and no late O_VALID appears.
REQ-041 I_ENABLE low for 4 cycles during LSH A=0x0001 B=2 -> latency stretches by 4, O_C=0x0004.
